// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU block buffer.
//   rd_state_t  - read-side FSM encoding (idle / fetch / present)
//   ZIGZAG_LUT  - JPEG zigzag scan: entry k is the raster position of the
//                 k-th coefficient in zigzag order (8x8 blocks only)
//   log2()      - ceiling log2 for sizing address fields
package mcu_pkg;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_FETCH   = 2'd1,
    RD_PRESENT = 2'd2
  } rd_state_t;

  localparam int unsigned ZZ_LEN = 64;

  localparam logic [5:0] ZIGZAG_LUT [ZZ_LEN] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcu_bank_ram.sv
// mcu_bank_ram: simple dual-port RAM holding both ping-pong banks.
// The bank select is the address MSB. Read data is registered and only
// updates when re is high, so the output holds while the consumer stalls.
// Contents and read register are not reset.
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read request (data appears on rdata one cycle later)
//   rdata        - registered read data
module mcu_bank_ram #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mcu_block_buffer.sv
// mcu_block_buffer: ping-pong collector that packs the subsampled sample
// stream into BLK_W x BLK_H blocks and replays each full block over a
// valid/ready handshake. One bank fills while the other drains.
// Build option: define ZIGZAG_EN for JPEG zigzag read order (8x8 only);
// otherwise blocks are replayed in raster order.
//   i_arst      - asynchronous active-high reset
//   i_sysclk    - clock
//   i_we        - input sample strobe (no backpressure)
//   i_color     - input sample
//   o_valid     - output sample valid
//   i_ready     - downstream accept
//   o_color     - output sample (0 when o_valid is low)
//   o_last      - final sample of a block
//   o_overflow  - sticky: a sample arrived while both banks were full
import mcu_pkg::*;

module mcu_block_buffer #(
  parameter int unsigned BLK_W           = 8,
  parameter int unsigned BLK_H           = 8,
  parameter int unsigned COLOR_PRECISION = 8
) (
  input  logic                       i_arst,
  input  logic                       i_sysclk,
  input  logic                       i_we,
  input  logic [COLOR_PRECISION-1:0] i_color,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [COLOR_PRECISION-1:0] o_color,
  output logic                       o_last,
  output logic                       o_overflow
);

  localparam int unsigned N  = BLK_W * BLK_H;
  localparam int unsigned AW = log2(N);
  localparam logic [AW-1:0] IDX_LAST = '1;

  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic [AW-1:0] rd_idx;
  logic          rd_bank;
  logic [1:0]    bank_full;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  rd_state_t state, state_nxt;

  logic          wr_en;
  logic          wr_done;
  logic          rd_hs;
  logic          rd_done;
  logic          rd_en;
  logic [AW-1:0] rd_sel;
  logic [AW-1:0] rd_map;
  logic [COLOR_PRECISION-1:0] rd_data;

  // ---------------- write side ----------------
  assign wr_en   = i_we && !bank_full[wr_bank];
  assign wr_done = wr_en && (wr_addr == IDX_LAST);

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      wr_addr    <= '0;
      wr_bank    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (i_we && bank_full[wr_bank]) o_overflow <= 1'b1;
    end
  end

  // Writer sets and reader clears always target different banks in the
  // same cycle, so both can be applied together.
  assign full_set = wr_done ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) bank_full <= '0;
    else        bank_full <= (bank_full | full_set) & ~full_clr;
  end

  // ---------------- read side ----------------
  assign rd_hs   = (state == RD_PRESENT) && i_ready;
  assign rd_done = rd_hs && (rd_idx == IDX_LAST);

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      state   <= RD_IDLE;
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_hs) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  // On a mid-block handshake the next sample is fetched in the same cycle
  // (index rd_idx+1) so the stream stays back-to-back.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_sel    = rd_idx;
    case (state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) state_nxt = RD_FETCH;
      end
      RD_FETCH: begin
        rd_en     = 1'b1;
        state_nxt = RD_PRESENT;
      end
      RD_PRESENT: begin
        if (i_ready) begin
          if (rd_idx == IDX_LAST) begin
            state_nxt = RD_IDLE;
          end else begin
            rd_en  = 1'b1;
            rd_sel = rd_idx + 1'b1;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

`ifdef ZIGZAG_EN
  if (BLK_W != 8 || BLK_H != 8) begin : g_zz_geom_err
    $error("mcu_block_buffer: ZIGZAG_EN requires BLK_W = BLK_H = 8");
  end
  assign rd_map = AW'(ZIGZAG_LUT[rd_sel]);
`else
  assign rd_map = rd_sel;
`endif

  mcu_bank_ram #(
    .ADDR_W (AW + 1),
    .DATA_W (COLOR_PRECISION)
  ) u_ram (
    .clk   (i_sysclk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_addr}),
    .wdata (i_color),
    .re    (rd_en),
    .raddr ({rd_bank, rd_map}),
    .rdata (rd_data)
  );

  // RAM read register is unreset; gating keeps o_color at 0 outside PRESENT.
  assign o_valid = (state == RD_PRESENT);
  assign o_last  = o_valid && (rd_idx == IDX_LAST);
  assign o_color = o_valid ? rd_data : '0;

endmodule

// File: tb/tb_mcu_block_buffer.sv
// tb_mcu_block_buffer: directed self-checking bench for mcu_block_buffer
// (8x8, 8-bit samples). Expected output order follows ZIGZAG_EN if defined.
module tb_mcu_block_buffer;

  localparam int RDY_ONE  = 0;
  localparam int RDY_RAND = 1;
  localparam int RDY_ZERO = 2;

  logic       i_arst;
  logic       i_sysclk;
  logic       i_we;
  logic [7:0] i_color;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_color;
  logic       o_last;
  logic       o_overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int order [64];

`ifdef ZIGZAG_EN
  localparam int ZZ_TAB [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
`endif

  mcu_block_buffer #(
    .BLK_W           (8),
    .BLK_H           (8),
    .COLOR_PRECISION (8)
  ) dut (
    .i_arst     (i_arst),
    .i_sysclk   (i_sysclk),
    .i_we       (i_we),
    .i_color    (i_color),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_color    (o_color),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_sysclk);
    #1;
  endtask

  // Drives nw writes (value wbase+w) while consuming nexp output samples.
  // Output sample k is expected to be rbase + 64*(k/64) + order[k%64].
  task automatic run(input string tag, input int nw, input int wbase,
                     input int nexp, input int rbase, input int mode);
    int w;
    int k;
    int cyc;
    int budget;
    int expv;
    logic stalled;
    logic [7:0] held_c;
    logic held_l;
    w = 0; k = 0; cyc = 0; stalled = 1'b0; held_c = '0; held_l = 1'b0;
    budget = 4 * (nw + nexp) + 100;
    while (!(w == nw && k == nexp) && cyc < budget) begin
      if (stalled) begin
        chk({tag, " stall_valid"}, 32'(o_valid), 32'd1);
        chk({tag, " stall_color"}, 32'(o_color), 32'(held_c));
        chk({tag, " stall_last"},  32'(o_last),  32'(held_l));
      end
      stalled = 1'b0;
      case (mode)
        RDY_ONE:  i_ready = 1'b1;
        RDY_RAND: i_ready = 1'($urandom_range(0, 1));
        default:  i_ready = 1'b0;
      endcase
      if (mode == RDY_ONE && k < nexp && (k % 64) != 0)
        chk({tag, " b2b_valid"}, 32'(o_valid), 32'd1);
      if (o_valid && k < nexp) begin
        if (i_ready) begin
          expv = (rbase + (k / 64) * 64 + order[k % 64]) % 256;
          chk({tag, " color"}, 32'(o_color), 32'(expv));
          chk({tag, " last"},  32'(o_last),  32'((k % 64) == 63));
          k++;
        end else begin
          stalled = 1'b1;
          held_c  = o_color;
          held_l  = o_last;
        end
      end
      if (w < nw) begin
        i_we    = 1'b1;
        i_color = 8'((wbase + w) % 256);
        w++;
      end else begin
        i_we = 1'b0;
      end
      tick();
      cyc++;
    end
    i_we = 1'b0;
    chk({tag, " completed"}, 32'(w == nw && k == nexp), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
`ifdef ZIGZAG_EN
      order[i] = ZZ_TAB[i];
`else
      order[i] = i;
`endif
    end

    i_arst  = 1'b1;
    i_we    = 1'b0;
    i_color = '0;
    i_ready = 1'b0;
    #3;
    chk("rst_valid",    32'(o_valid),    32'd0);
    chk("rst_color",    32'(o_color),    32'd0);
    chk("rst_last",     32'(o_last),     32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    tick();
    tick();
    i_arst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(o_valid), 32'd0);

    // First block: latency from the completing write, then a full drain.
    run("lat_wr", 64, 0, 0, 0, RDY_ONE);
    chk("lat_t0_valid", 32'(o_valid), 32'd0);
    tick();
    chk("lat_t1_valid", 32'(o_valid), 32'd0);
    tick();
    chk("lat_t2_valid", 32'(o_valid), 32'd1);
    chk("lat_t2_color", 32'(o_color), 32'(order[0]));
    chk("lat_t2_last",  32'(o_last),  32'd0);
    run("blk0", 0, 0, 64, 0, RDY_ONE);
    chk("blk0_overflow", 32'(o_overflow), 32'd0);

    // Random backpressure while writing.
    run("bp", 64, 64, 64, 64, RDY_RAND);
    chk("bp_overflow", 32'(o_overflow), 32'd0);

    // Ping-pong: two consecutive blocks.
    run("pp", 128, 0, 128, 0, RDY_ONE);
    chk("pp_overflow", 32'(o_overflow), 32'd0);
    tick();
    chk("pp_idle_valid", 32'(o_valid), 32'd0);

    // Overflow: both banks full, then one more sample.
    run("ovf_fill", 128, 0, 0, 0, RDY_ZERO);
    chk("ovf_before", 32'(o_overflow), 32'd0);
    run("ovf_extra", 1, 128, 0, 0, RDY_ZERO);
    chk("ovf_after", 32'(o_overflow), 32'd1);
    run("ovf_drain", 0, 0, 128, 0, RDY_ONE);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    tick();
    tick();
    chk("ovf_lost_valid", 32'(o_valid), 32'd0);

    // Reset mid-output with a partial block pending in the other bank.
    run("pre_rst", 74, 10, 20, 10, RDY_ONE);
    i_arst = 1'b1;
    #1;
    chk("mid_rst_valid",    32'(o_valid),    32'd0);
    chk("mid_rst_color",    32'(o_color),    32'd0);
    chk("mid_rst_last",     32'(o_last),     32'd0);
    chk("mid_rst_overflow", 32'(o_overflow), 32'd0);
    #2;
    i_arst = 1'b0;
    tick();
    chk("rel_rst_valid", 32'(o_valid), 32'd0);
    run("post_rst", 64, 150, 64, 150, RDY_ONE);
    tick();
    tick();
    tick();
    chk("final_valid",    32'(o_valid),    32'd0);
    chk("final_overflow", 32'(o_overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
